// File: rtl/mem_rmw_pkg.sv
// Shared types and helpers for the port-b data-side RMW controller.
// Holds the FSM state enum, strobe constants and the byte-lane merge.
package mem_rmw_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RD_RESP,
      RMW_WR,
      WR_RESP
   } state_e;

   localparam logic [3:0] WSTRB_FULL = 4'hF;
   localparam logic [3:0] WSTRB_NONE = 4'h0;

   // Per byte lane: take the new byte where the strobe is set,
   // otherwise keep the old byte.
   function automatic logic [31:0] byte_merge(
      input logic [31:0] old_w,
      input logic [31:0] new_w,
      input logic [3:0]  strb
   );
      logic [31:0] m;
      m = old_w;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) m[8*i +: 8] = new_w[8*i +: 8];
      end
      return m;
   endfunction

endpackage

// File: rtl/mem_rmw_ctrl_byte_merge.sv
// Combinational 4-lane byte merge used by the RMW write cycle.
// Ports: old_word/new_word/strb in, merged out.
module rmw_byte_merge
   import mem_rmw_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] new_word,
   input  logic [3:0]  strb,
   output logic [31:0] merged
);

   always_comb begin
      merged = byte_merge(old_word, new_word, strb);
   end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// Port-b data-side front end: loads, full stores, sub-word RMW stores.
// Ports: core mem_* handshake, SRAM sram_* port, rmw_cnt statistics.
module mem_rmw_ctrl
   import mem_rmw_pkg::*;
#(
   parameter int AW    = 13,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_req,
   input  logic             mem_we,
   input  logic [3:0]       mem_wstrb,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   output logic             mem_ready,
   output logic [31:0]      mem_rdata,
   output logic             sram_rd,
   output logic             sram_we,
   output logic [31:0]      sram_addr,
   output logic [31:0]      sram_din,
   input  logic [31:0]      sram_dout,
   output logic [CNT_W-1:0] rmw_cnt
);

   state_e        state_q;
   state_e        state_d;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic [31:0]   rdata_q;
   logic [AW-1:0] word_sel;
   logic [31:0]   merged_word;
   logic          part_q;
   logic          is_ld;
   logic          is_full;
   logic          is_none;
   logic          is_part;
   logic          unused_addr;

   assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};

   // Mutually exclusive request classes for the IDLE decoder
   assign is_ld   = !mem_we;
   assign is_full = mem_we && (mem_wstrb == WSTRB_FULL);
   assign is_none = mem_we && (mem_wstrb == WSTRB_NONE);
   assign is_part = mem_we && !is_full && !is_none;

   assign part_q = (wstrb_q != WSTRB_FULL) && (wstrb_q != WSTRB_NONE);

   assign sram_addr = {{(32-AW){1'b0}}, word_sel};

   rmw_byte_merge u_merge (
      .old_word (sram_dout),
      .new_word (wdata_q),
      .strb     (wstrb_q),
      .merged   (merged_word)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         rmw_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && mem_req) begin
            addr_q  <= mem_addr[AW+1:2];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
         end
         if (state_q == RMW_WR) rdata_q <= sram_dout;
         if (state_q == WR_RESP && part_q && rmw_cnt != '1) begin
            rmw_cnt <= rmw_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      mem_ready = 1'b0;
      mem_rdata = '0;
      sram_rd   = 1'b0;
      sram_we   = 1'b0;
      sram_din  = '0;
      word_sel  = addr_q;
      unique case (state_q)
         IDLE: begin
            // Address comes straight from the core so the
            // first SRAM access happens in the request cycle.
            word_sel = mem_addr[AW+1:2];
            if (mem_req) begin
               unique case (1'b1)
                  is_ld: begin
                     sram_rd = 1'b1;
                     state_d = RD_RESP;
                  end
                  is_full: begin
                     sram_we  = 1'b1;
                     sram_din = mem_wdata;
                     state_d  = WR_RESP;
                  end
                  is_none: begin
                     state_d = WR_RESP;
                  end
                  is_part: begin
                     sram_rd = 1'b1;
                     state_d = RMW_WR;
                  end
                  default: begin
                     state_d = IDLE;
                  end
               endcase
            end
         end
         RD_RESP: begin
            mem_ready = 1'b1;
            mem_rdata = sram_dout;
            state_d   = IDLE;
         end
         RMW_WR: begin
            sram_we  = 1'b1;
            sram_din = merged_word;
            state_d  = WR_RESP;
         end
         WR_RESP: begin
            mem_ready = 1'b1;
            mem_rdata = part_q ? rdata_q : 32'h0;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Reset kills any in-flight access immediately,
      // including the RMW write.
      if (!rst_n) begin
         mem_ready = 1'b0;
         mem_rdata = '0;
         sram_rd   = 1'b0;
         sram_we   = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Self-checking bench for mem_rmw_ctrl with a behavioural SRAM
// and a word-array reference model of the memory and counter.
module tb_mem_rmw_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        sram_rd;
   logic        sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout = 32'h0;
   logic [1:0]  rmw_cnt;

   int checks   = 0;
   int failures = 0;
   int rd_seen  = 0;
   int we_seen  = 0;
   int rdy_seen = 0;
   int exp_cnt  = 0;

   logic [31:0] sram_mem [32];
   logic [31:0] ref_mem  [32];

   always #5 clk = ~clk;

   mem_rmw_ctrl #(.AW(13), .CNT_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_wstrb (mem_wstrb),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .sram_rd   (sram_rd),
      .sram_we   (sram_we),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .sram_dout (sram_dout),
      .rmw_cnt   (rmw_cnt)
   );

   always @(posedge clk) begin
      if (sram_rd) sram_dout <= sram_mem[sram_addr[4:0]];
      if (sram_we) sram_mem[sram_addr[4:0]] <= sram_din;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         rd_seen  = rd_seen + int'(sram_rd);
         we_seen  = we_seen + int'(sram_we);
         rdy_seen = rdy_seen + int'(mem_ready);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic xact(input logic we, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] data,
                       input bit hold);
      int          idx;
      bit          part;
      int          exp_lat;
      int          exp_rd;
      int          exp_we;
      int          lat;
      bit          got;
      int          rd0;
      int          we0;
      int          rdy0;
      logic [31:0] old_w;
      logic [31:0] new_w;
      logic [31:0] exp_rdata;
      logic [31:0] waddr;
      idx     = int'(addr[6:2]);
      waddr   = {19'h0, addr[14:2]};
      part    = we && strb != 4'h0 && strb != 4'hF;
      exp_lat = part ? 2 : 1;
      exp_rd  = (!we || part) ? 1 : 0;
      exp_we  = (we && strb != 4'h0) ? 1 : 0;
      old_w   = ref_mem[idx];
      new_w   = old_w;
      for (int b = 0; b < 4; b++) begin
         if (we && strb[b]) new_w[8*b +: 8] = data[8*b +: 8];
      end
      exp_rdata = (!we || part) ? old_w : 32'h0;
      rd0  = rd_seen;
      we0  = we_seen;
      rdy0 = rdy_seen;
      @(posedge clk);
      #1;
      mem_req   = 1'b1;
      mem_we    = we;
      mem_wstrb = strb;
      mem_addr  = addr;
      mem_wdata = data;
      lat = 0;
      got = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk("rd_we_excl", {31'h0, sram_rd & sram_we}, 32'h0);
         if (n == 0 && exp_rd + exp_we > 0) chk("addr", sram_addr, waddr);
         if (n == 0 && we && strb == 4'hF) chk("din_full", sram_din, data);
         if (n == 1 && part) begin
            chk("we_rmw", {31'h0, sram_we}, 32'h1);
            chk("addr_rmw", sram_addr, waddr);
            chk("din_rmw", sram_din, new_w);
         end
         if (mem_ready) begin
            lat = n;
            got = 1;
            chk("rdata", mem_rdata, exp_rdata);
            break;
         end
      end
      if (!got) chk("ready_timeout", 32'h0, 32'h1);
      chk("latency", lat, exp_lat);
      if (!hold) mem_req = 1'b0;
      @(posedge clk);
      #1;
      mem_req = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      if (we) ref_mem[idx] = new_w;
      if (part && exp_cnt < 3) exp_cnt++;
      chk("rmw_cnt", {30'h0, rmw_cnt}, exp_cnt);
      chk("rd_count", rd_seen - rd0, exp_rd);
      chk("we_count", we_seen - we0, exp_we);
      chk("ready_count", rdy_seen - rdy0, 1);
   endtask

   initial begin
      logic [3:0] s;
      rst_n     = 1'b0;
      mem_req   = 1'b1;
      mem_we    = 1'b0;
      mem_wstrb = 4'hF;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
      @(negedge clk);
      chk("rst_rd", {31'h0, sram_rd}, 32'h0);
      chk("rst_ready", {31'h0, mem_ready}, 32'h0);
      chk("rst_rdata", mem_rdata, 32'h0);
      mem_we = 1'b1;
      #1;
      chk("rst_we", {31'h0, sram_we}, 32'h0);
      @(posedge clk);
      #1;
      mem_req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_cnt", {30'h0, rmw_cnt}, 32'h0);

      for (int i = 0; i < 32; i++) begin
         xact(1'b1, 4'hF, 32'(i) << 2, $urandom, 0);
      end

      xact(1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 0);
      xact(1'b0, 4'h0, 32'h40, 32'h0, 0);
      xact(1'b1, 4'hF, 32'h08, 32'h11223344, 0);
      xact(1'b1, 4'h5, 32'h08, 32'hAABBCCDD, 0);
      chk("t2_word", sram_mem[2], 32'h11BB33DD);
      xact(1'b1, 4'h0, 32'h0C, 32'hFFFFFFFF, 0);
      xact(1'b0, 4'h0, 32'h40, 32'h0, 1);
      xact(1'b1, 4'h6, 32'h44, 32'h01020304, 1);

      xact(1'b1, 4'hF, 32'h20, 32'h55AA55AA, 0);
      @(posedge clk);
      #1;
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_wstrb = 4'h3;
      mem_addr  = 32'h20;
      mem_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rmw_rst_we", {31'h0, sram_we}, 32'h0);
      chk("rmw_rst_ready", {31'h0, mem_ready}, 32'h0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      mem_req = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      chk("rmw_rst_cnt", {30'h0, rmw_cnt}, 32'h0);
      chk("rmw_rst_idle", {31'h0, mem_ready | sram_rd | sram_we}, 32'h0);
      chk("rmw_rst_word", sram_mem[8], 32'h55AA55AA);
      xact(1'b0, 4'h0, 32'h20, 32'h0, 0);

      for (int k = 0; k < 5; k++) begin
         xact(1'b1, 4'(k + 1), 32'(k) << 2, $urandom, 0);
      end

      for (int k = 0; k < 80; k++) begin
         case ($urandom_range(0, 3))
            0: s = 4'h0;
            1: s = 4'hF;
            default: s = 4'($urandom);
         endcase
         xact(1'($urandom), s, 32'($urandom_range(0, 127)), $urandom,
              1'($urandom));
      end

      for (int i = 0; i < 32; i++) chk("mem_final", sram_mem[i], ref_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
